// File: rtl/exp_align_serializer.sv
// exp_align_serializer
// Captures one group of nine FP16 product lanes plus the group max exponent,
// then streams each lane right-aligned to the max exponent (with guard bits
// and a sticky bit) one per cycle over a valid/ready handshake.

module exp_align_serializer #(
    parameter int EXP_W = 6,
    parameter int SIG_W = 22,
    parameter int GRD_W = 3,
    parameter int ALN_W = SIG_W + GRD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8:0]           skip,
    input  logic [EXP_W-1:0]     max_exp,
    input  logic [9*EXP_W-1:0]   exp_bus,
    input  logic [9*SIG_W-1:0]   sig_bus,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ALN_W-1:0]     out_sig,
    output logic                 out_sticky,
    output logic [3:0]           out_idx,
    output logic                 out_last,
    output logic                 out_err
);

    localparam int LANES = 9;
    localparam logic [3:0] LAST_IDX = 4'd8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    logic [3:0] idx_q;
    logic [3:0] idx_d;

    // Captured group, stored per lane in lane order (lane 0 = first product)
    logic             cap_skip [LANES];
    logic [EXP_W-1:0] cap_exp  [LANES];
    logic [SIG_W-1:0] cap_sig  [LANES];
    logic [EXP_W-1:0] cap_max;

    // Unpacked view of the incoming buses
    logic             in_skip  [LANES];
    logic [EXP_W-1:0] in_exp   [LANES];
    logic [SIG_W-1:0] in_sig   [LANES];

    logic accept;

    // Currently selected lane and its alignment results
    logic             lane_skip;
    logic [EXP_W-1:0] lane_exp;
    logic [SIG_W-1:0] lane_sig;
    logic             lane_err;
    logic [EXP_W-1:0] shamt;
    logic [ALN_W-1:0] ext;
    logic [ALN_W-1:0] lost_mask;
    logic [ALN_W-1:0] aligned;
    logic             aligned_sticky;

    assign accept = in_valid && (state_q == IDLE);

    // Split the packed buses into lanes; the MSB-most slice belongs to lane 0
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            in_skip[k] = skip[LANES-1-k];
            in_exp[k]  = exp_bus[(LANES-1-k)*EXP_W +: EXP_W];
            in_sig[k]  = sig_bus[(LANES-1-k)*SIG_W +: SIG_W];
        end
    end

    // Group capture registers, loaded only when a group is accepted in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_max <= '0;
            for (int k = 0; k < LANES; k++) begin
                cap_skip[k] <= 1'b0;
                cap_exp[k]  <= '0;
                cap_sig[k]  <= '0;
            end
        end else if (accept) begin
            cap_max <= max_exp;
            for (int k = 0; k < LANES; k++) begin
                cap_skip[k] <= in_skip[k];
                cap_exp[k]  <= in_exp[k];
                cap_sig[k]  <= in_sig[k];
            end
        end
    end

    // State and lane index registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic: accept a group in IDLE, walk lanes 0..8 in SHIFT
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (in_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Select the captured lane addressed by the current index
    always_comb begin
        lane_skip = 1'b0;
        lane_exp  = '0;
        lane_sig  = '0;
        for (int k = 0; k < LANES; k++) begin
            if (idx_q == 4'(k)) begin
                lane_skip = cap_skip[k];
                lane_exp  = cap_exp[k];
                lane_sig  = cap_sig[k];
            end
        end
    end

    // Right-align the selected significand and collect the bits shifted out
    always_comb begin
        lane_err       = (lane_exp > cap_max);
        shamt          = lane_err ? '0 : (cap_max - lane_exp);
        ext            = {lane_sig, {GRD_W{1'b0}}};
        lost_mask      = '0;
        aligned        = '0;
        aligned_sticky = 1'b0;
        if (shamt < EXP_W'(ALN_W)) begin
            lost_mask      = ~({ALN_W{1'b1}} << shamt);
            aligned        = ext >> shamt;
            aligned_sticky = |(ext & lost_mask);
        end else begin
            aligned        = '0;
            aligned_sticky = |lane_sig;
        end
    end

    // Output decode from registered state only; IDLE presents zeros
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_sig    = '0;
        out_sticky = 1'b0;
        out_err    = 1'b0;
        out_last   = 1'b0;
        out_idx    = idx_q;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                out_valid = 1'b1;
                out_last  = (idx_q == LAST_IDX);
                if (!lane_skip) begin
                    out_sig    = aligned;
                    out_sticky = aligned_sticky;
                    out_err    = lane_err;
                end
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/exp_align_serializer.md
Name: exp_align_serializer

Overview:
- Consumer side of the max-exponent determination stage in the MAC subsystem.
- Accepts one group of 9 FP16 product lanes (exponent, significand, skip) together with the group's max exponent.
- Right-aligns each significand to the max exponent, with guard bits and a sticky bit.
- Streams the aligned lanes, one per cycle, to the downstream accumulator adder over a valid/ready handshake.

Parameters:
- EXP_W, 6, exponent width (FP16_exp_width+1).
- SIG_W, 22, product significand width (11b x 11b).
- GRD_W, 3, guard bits appended below the significand LSB.
- ALN_W, SIG_W+GRD_W (25), aligned output width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  group valid.
- in_ready  out  1  block can accept a group.
- skip  in  9  skip[8-k]=1 marks lane k as zero (lane 0 = first product).
- max_exp  in  EXP_W  group max exponent.
- exp_bus  in  9*EXP_W  lane k at [(8-k)*EXP_W +: EXP_W].
- sig_bus  in  9*SIG_W  lane k at [(8-k)*SIG_W +: SIG_W].
- out_valid  out  1  aligned lane valid.
- out_ready  in  1  downstream accepts the lane.
- out_sig  out  ALN_W  aligned significand.
- out_sticky  out  1  OR of all bits shifted out.
- out_idx  out  4  lane index 0..8.
- out_last  out  1  high when out_idx==8.
- out_err  out  1  lane exp > max_exp (non-skipped lane).

Behaviour:
- One clock domain; rst is asynchronous and active-high.
- Reset:
  - state=IDLE, idx=0, captured registers=0.
  - out_valid=0, out_sig=0, out_sticky=0, out_idx=0, out_last=0, out_err=0.
  - in_ready=1 once reset is deasserted.
- States: IDLE, SHIFT.
- IDLE:
  - in_ready=1, out_valid=0.
  - in_valid&&in_ready: capture skip, max_exp, exp_bus, sig_bus; set idx=0; go to SHIFT.
- SHIFT:
  - in_ready=0, out_valid=1.
  - The first lane is valid the cycle after acceptance (latency 1).
  - out_valid&&out_ready: idx==8 → IDLE (idx=0); otherwise idx+1.
  - A stall (out_ready=0) holds every out_* stable.
- Back-to-back groups are not overlapped: minimum 10 cycles per group. in_ready rises the cycle after the last transfer.
- Per-lane arithmetic (from captured registers and idx):
  - skip set → out_sig=0, out_sticky=0, out_err=0 (exp and sig ignored).
  - exp_i > max_exp → out_err=1, shamt forced to 0.
  - Otherwise shamt = max_exp - exp_i (unsigned, EXP_W bits).
  - ext = {sig_i, GRD_W'b0}.
  - shamt < ALN_W → out_sig = ext >> shamt; out_sticky = OR of ext bits [shamt-1:0] (0 when shamt=0).
  - shamt ≥ ALN_W → out_sig=0, out_sticky=|sig_i.
- out_idx = idx; out_last = (idx==8) while in SHIFT.
- out_* may be driven combinationally from registered state. They must not depend on in_* or out_ready in the same cycle.
- In IDLE, out_sig, out_sticky and out_err are 0.
- Reset mid-group: the group is dropped, state returns to IDLE, outputs return to reset values, and no partial completion occurs.
- in_valid while in SHIFT is ignored; upstream must hold it until in_ready.

Test Plan:
- Basic alignment: max_exp=20; lane 0 exp=17, sig=22'h200000; other lanes skipped; out_ready=1.
  - Lane 0: out_sig=25'h0200000, out_sticky=0, out_err=0.
  - Lanes 1-8: out_sig=0.
  - out_last on idx 8.
  - in_ready back to 1 on cycle 11.
- Sticky: max_exp=10, lane 0 exp=5, sig=22'h000001 (shamt 5) → out_sig=0, out_sticky=1.
  - Same with exp=7 (shamt 3) → out_sig=1, out_sticky=0.
- Saturation: max_exp=40, exp=10 (shamt 30) → out_sig=0, out_sticky=1.
  - Same with sig=0 → out_sticky=0.
- Error: max_exp=12, lane 4 exp=15, sig=22'h3FFFFF, not skipped → idx 4 shows out_err=1, out_sig=25'h1FFFFF8.
- Backpressure: out_ready=0 for 3 cycles at idx 2 → outputs held stable; total transfers=9; out_idx sequence 0..8 with no gaps or repeats.
- Reset mid-group: assert rst asynchronously at idx 5 → out_valid falls immediately, in_ready=1 after release; the next group starts at idx 0.
